// File: rtl/mult_job_sequencer.sv
// Job sequencer wrapped around a Booth multiplier: buffers operand pairs in a small FIFO,
// launches one multiply at a time, and returns the signed product (or a timeout) over valid/ready.
module mult_job_sequencer #(
    parameter int WIDTH        = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int RESULT_DELAY = 1,
    parameter int TIMEOUT      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_multiplicand,
    input  logic [WIDTH-1:0]     in_multiplier,
    output logic [WIDTH-1:0]     multiplicand,
    output logic [WIDTH-1:0]     multiplier,
    output logic                 start,
    input  logic                 finished,
    input  logic [2*WIDTH-1:0]   result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_timeout,
    output logic                 busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DW = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY) : 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    // WAIT exits when the incremented timer would reach TIMEOUT-1
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);
    localparam logic [DW-1:0] DELAY_LAST = DW'(RESULT_DELAY - 1);

    typedef logic [2*WIDTH-1:0] entry_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // FIFO storage and pointers
    entry_t          fifo_mem_q [FIFO_DEPTH];
    entry_t          fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;

    // Sequencer state
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            finished_q;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            start_q, start_d;
    logic            out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_product_q, out_product_d;
    logic            out_timeout_q, out_timeout_d;
    logic            busy_q, busy_d;

    logic            push_s;
    logic            pop_s;
    logic            rise_s;
    entry_t          head_s;

    assign in_ready    = in_ready_q;
    assign multiplicand = mcand_q;
    assign multiplier  = mplier_q;
    assign start       = start_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_timeout = out_timeout_q;
    assign busy        = busy_q;

    // FIFO next-state: push/pop handshakes, pointer and occupancy update
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_s     = in_valid & in_ready_q;
        pop_s      = (state_q == ST_IDLE) && (count_q != '0);
        head_s     = fifo_mem_q[rd_ptr_q];

        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = {in_multiplicand, in_multiplier};
            wr_ptr_d             = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // in_ready is a flop of the next occupancy, so it never depends on this cycle's pop
        in_ready_d = (count_d != FULL_CNT);
    end

    // Sequencer next-state and output computation
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        dcnt_d        = dcnt_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        start_d       = 1'b0;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_timeout_d = out_timeout_q;
        rise_s        = finished & ~finished_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    mcand_d  = head_s[2*WIDTH-1:WIDTH];
                    mplier_d = head_s[WIDTH-1:0];
                    start_d  = 1'b1;
                    state_d  = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                // A rise coinciding with the last timer cycle still counts as a completion
                if (rise_s) begin
                    dcnt_d  = '0;
                    state_d = ST_SETTLE;
                end else if (timer_q == TIMER_LAST) begin
                    out_product_d = '0;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (dcnt_q == DELAY_LAST) begin
                    out_product_d = result;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    dcnt_d  = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
                    state_d = ST_SETTLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    // FIFO register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            dcnt_q        <= '0;
            finished_q    <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            start_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            dcnt_q        <= dcnt_d;
            finished_q    <= finished;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            start_q       <= start_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_timeout_q <= out_timeout_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural 4-cycle multiplier model.
module tb_mult_job_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_multiplicand;
    logic [3:0] in_multiplier;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       start;
    logic       finished;
    logic [7:0] result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic       out_timeout;
    logic       busy;

    logic       tie0;
    int         n_checks = 0;
    int         n_fail   = 0;

    mult_job_sequencer #(
        .WIDTH(4), .FIFO_DEPTH(2), .RESULT_DELAY(1), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .start(start), .finished(finished), .result(result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_timeout(out_timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: finished rises 4 cycles after start, holds until next start
    logic [2:0] m_cnt;
    logic       m_fin;
    logic [7:0] m_res;
    logic [7:0] m_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 3'd0; m_fin <= 1'b0; m_res <= 8'h00; m_pend <= 8'h00;
        end else if (start) begin
            m_cnt  <= 3'd4;
            m_fin  <= 1'b0;
            m_pend <= {{4{multiplicand[3]}}, multiplicand} * {{4{multiplier[3]}}, multiplier};
        end else if (m_cnt == 3'd1) begin
            m_fin <= 1'b1; m_res <= m_pend; m_cnt <= 3'd0;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end
    end
    assign finished = m_fin & ~tie0;
    assign result   = m_res;

    // Monitor: cycle stamps, accepted jobs, delivered results, output stability
    int         cyc = 0, start_cyc = 0, fin_cyc = 0, ov_cyc = 0;
    int         start_cnt = 0, acc_cnt = 0, res_n = 0, stab_err = 0;
    logic       fin_prev = 1'b0, ov_prev = 1'b0, holding = 1'b0;
    logic [8:0] hold_val = 9'h000;
    logic [8:0] res_mem [0:63];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) begin start_cyc <= cyc; start_cnt <= start_cnt + 1; end
        if (finished && !fin_prev) fin_cyc <= cyc;
        fin_prev <= finished;
        if (out_valid && !ov_prev) ov_cyc <= cyc;
        ov_prev <= out_valid;
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (out_valid && out_ready && res_n < 64) begin
            res_mem[res_n] <= {out_timeout, out_product};
            res_n <= res_n + 1;
        end
        if (holding && ({out_timeout, out_product} != hold_val)) stab_err <= stab_err + 1;
        holding  <= out_valid && !out_ready;
        hold_val <= {out_timeout, out_product};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the handshake edge
    task automatic push_job(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1; in_multiplicand = a; in_multiplier = b;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("push_bound", (n >= 200), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int k = 0;
        while (res_n < target && k < 400) begin @(posedge clk); #1; k++; end
        check_eq("result_count", res_n, target);
    endtask

    logic [3:0] t3_a [4], t3_b [4], t6_a [6], t6_b [6];
    logic [8:0] t3_e [4], t6_e [6];
    int         base, acc0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t3_a = '{4'h1, 4'h2, 4'hD, 4'h6}; t3_b = '{4'h1, 4'hE, 4'h3, 4'hB};
        t3_e = '{9'h001, 9'h0FC, 9'h0F7, 9'h0E2};
        t6_a = '{4'hF, 4'h7, 4'h8, 4'h4, 4'h0, 4'h9};
        t6_b = '{4'hF, 4'h7, 4'h7, 4'hD, 4'hB, 4'h2};
        t6_e = '{9'h001, 9'h031, 9'h0C8, 9'h0F4, 9'h000, 9'h0F2};

        rst_n = 1'b1; in_valid = 1'b0; in_multiplicand = 4'h0; in_multiplier = 4'h0;
        out_ready = 1'b1; tie0 = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_start", start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_product", out_product, 0);
        check_eq("rst_mcand", multiplicand, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single job 3 x -2, start timing and latency
        push_job(4'h3, 4'hE);
        check_eq("t1_start_n1", start, 0);
        @(posedge clk); #1;
        check_eq("t1_start_n2", start, 1);
        check_eq("t1_mcand", multiplicand, 4'h3);
        check_eq("t1_mplier", multiplier, 4'hE);
        check_eq("t1_busy", busy, 1);
        @(posedge clk); #1;
        check_eq("t1_start_n3", start, 0);
        wait_results(1);
        check_eq("t1_product", res_mem[0], 9'h0FA);
        check_eq("t1_start_cnt", start_cnt, 1);
        check_eq("t1_latency", ov_cyc - fin_cyc, 2);
        @(posedge clk); #1;
        check_eq("t1_mcand_held", multiplicand, 4'h3);
        check_eq("t1_idle_busy", busy, 0);

        // 2: extreme operands, in order
        push_job(4'h8, 4'h8);
        push_job(4'h7, 4'h8);
        wait_results(3);
        check_eq("t2_first", res_mem[1], 9'h040);
        check_eq("t2_second", res_mem[2], 9'h0C8);

        // 3: backpressure fills one in flight plus FIFO_DEPTH buffered
        out_ready = 1'b0; acc0 = acc_cnt; base = res_n;
        fork
            begin
                for (int i = 0; i < 4; i++) push_job(t3_a[i], t3_b[i]);
            end
            begin
                repeat (12) begin @(posedge clk); #1; end
                check_eq("t3_accepted", acc_cnt - acc0, 3);
                check_eq("t3_in_ready", in_ready, 0);
                check_eq("t3_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        wait_results(base + 4);
        for (int i = 0; i < 4; i++) check_eq("t3_order", res_mem[base + i], t3_e[i]);

        // 4: finished stuck low -> timeout 32 cycles after start, then normal job
        tie0 = 1'b1; base = res_n;
        push_job(4'h2, 4'h3);
        wait_results(base + 1);
        check_eq("t4_timeout", res_mem[base], 9'h100);
        check_eq("t4_latency", ov_cyc - start_cyc, 32);
        tie0 = 1'b0;
        push_job(4'h2, 4'h3);
        wait_results(base + 2);
        check_eq("t4_recover", res_mem[base + 1], 9'h006);

        // 5: reset asserted while waiting for finished
        base = res_n;
        push_job(4'h5, 4'h5);
        repeat (3) begin @(posedge clk); #1; end
        check_eq("t5_in_wait", start_cnt > 0 && busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_start", start, 0);
        check_eq("t5_out_valid", out_valid, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_eq("t5_no_stale", res_n, base);
        push_job(4'h5, 4'h5);
        wait_results(base + 1);
        check_eq("t5_fresh", res_mem[base], 9'h019);

        // 6: random out_ready, stability and no loss/duplication
        base = res_n;
        fork
            begin
                for (int i = 0; i < 6; i++) push_job(t6_a[i], t6_b[i]);
            end
            begin
                int k = 0;
                while (res_n < base + 6 && k < 2000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1; k++;
                end
                out_ready = 1'b1;
            end
        join
        repeat (20) begin @(posedge clk); #1; end
        check_eq("t6_count", res_n, base + 6);
        for (int i = 0; i < 6; i++) check_eq("t6_order", res_mem[base + i], t6_e[i]);
        check_eq("t6_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
